// File: rtl/data_mem_port.sv
// Load/store port between the pipeline and data memory: one request per op,
// a req/ack handshake with timeout, and load results returned via the register-file write port.
module data_mem_port #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [3:0]        dest_reg,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] store_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_write,
  output logic [3:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic [1:0]        dbg_state
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       store_q;
  logic [3:0] dest_q;
  logic       accept;
  logic       ack_hit;
  logic       timeout_hit;

  // Handshake: mem_req is the valid and mem_ack the ready; a transfer occurs on an edge
  // where both are 1. mem_req, mem_we, mem_addr and mem_wdata stay stable until then or timeout.
  assign accept      = (state == S_IDLE) && start;
  assign ack_hit     = (state == S_REQ) && mem_ack;
  assign timeout_hit = (state == S_REQ) && !mem_ack && ((wait_cnt + 8'd1) == TIMEOUT_CNT);

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_REQ;
      S_REQ:   if (ack_hit || timeout_hit) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Decoded from state so an asynchronous reset drops mem_req and busy at once.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    wb_write = 1'b0;
    case (state)
      S_REQ: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = store_q;
      end
      S_FIN: begin
        busy     = 1'b1;
        done     = 1'b1;
        wb_write = !store_q && !error;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q   <= 1'b0;
      dest_q    <= 4'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wait_cnt  <= 8'd0;
      error     <= 1'b0;
      wb_reg    <= 4'd0;
      wb_data   <= '0;
    end else if (accept) begin
      store_q   <= is_store;
      dest_q    <= dest_reg;
      mem_addr  <= address;
      mem_wdata <= store_data;
      wait_cnt  <= 8'd0;
      error     <= 1'b0;
    end else if (state == S_REQ) begin
      if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
      if (timeout_hit) error <= 1'b1;
      // The ack wins over a coinciding timeout, so capture is keyed on ack alone.
      if (ack_hit && !store_q) begin
        wb_reg  <= dest_q;
        wb_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_port.sv
// Bench for data_mem_port: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the port.
module tb_data_mem_port;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start = 1'b0;
  logic          is_store = 1'b0;
  logic [3:0]    dest_reg = 4'd0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] store_data = '0;
  logic          busy, done, error, mem_req, mem_we, wb_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, wb_data;
  logic [3:0]    wb_reg;
  logic [1:0]    dbg_state;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  data_mem_port #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .dest_reg(dest_reg),
    .address(address), .store_data(store_data), .busy(busy), .done(done), .error(error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_write(wb_write), .wb_reg(wb_reg),
    .wb_data(wb_data), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int req_hi_cnt = 0;
  int wb_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int            ack_mode = 0;  // 0 never ack, 1 fixed delay, 2 random delay per op
  int            ack_delay = 0; // index of the REQ cycle that gets the ack
  bit            noise = 1'b0;  // spurious acks while no request is pending
  bit            use_fixed = 1'b0;
  logic [DW-1:0] fixed_rdata = '0;
  int            req_seen = 0;
  int            cur_delay = 0;

  always @(posedge clk) begin
    #1;
    if (mem_req) req_seen++; else req_seen = 0;
    if (req_seen == 1) cur_delay = (ack_mode == 2) ? int'($urandom_range(0, 17)) : ack_delay;
    mem_ack = 1'b0;
    if (mem_req && ack_mode != 0 && (req_seen - 1) == cur_delay) mem_ack = 1'b1;
    else if (!mem_req && noise) mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = use_fixed ? fixed_rdata : DW'($urandom);
  end

  // ---------------- transaction-level model ----------------
  bit            m_busy, m_fin, m_err, m_ok, m_store;
  int            m_req_cycles;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_wb_data;
  logic [3:0]    m_dest, m_wb_reg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_fin = 0; m_err = 0; m_ok = 0; m_store = 0; m_req_cycles = 0;
      m_addr = '0; m_wdata = '0; m_dest = '0; m_wb_reg = '0; m_wb_data = '0;
    end else if (m_fin) begin
      m_fin = 0; m_busy = 0; m_ok = 0;
    end else if (m_busy) begin
      m_req_cycles++;
      if (mem_ack) begin
        m_fin = 1;
        m_ok  = !m_store;
        if (!m_store) begin
          m_wb_reg  = m_dest;
          m_wb_data = mem_rdata;
        end
      end else if (m_req_cycles == TO) begin
        m_fin = 1;
        m_err = 1;
      end
    end else if (start) begin
      m_busy = 1; m_req_cycles = 0; m_err = 0;
      m_store = is_store; m_dest = dest_reg; m_addr = address; m_wdata = store_data;
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_fin));
    chk("mem_req", 32'(mem_req), 32'(m_busy && !m_fin));
    chk("error", 32'(error), 32'(m_err));
    chk("wb_write", 32'(wb_write), 32'(m_fin && m_ok));
    chk("wb_reg", 32'(wb_reg), 32'(m_wb_reg));
    chk("wb_data", 32'(wb_data), 32'(m_wb_data));
    if (m_busy && !m_fin) begin
      chk("mem_we", 32'(mem_we), 32'(m_store));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    end
    if (done) done_cnt++;
    if (mem_req) req_hi_cnt++;
    if (wb_write) wb_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL wait_idle: busy still 1 after 60 cycles");
    end
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL wait_done: no done pulse within 60 cycles");
    end
  endtask

  // Returns just after the accepting edge.
  task automatic issue(input bit st, input logic [3:0] d, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    wait_idle();
    start = 1'b1; is_store = st; dest_reg = d; address = a; store_data = wd;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_wb_write"}, 32'(wb_write), 32'd0);
    chk({tag, "_wb_reg"}, 32'(wb_reg), 32'd0);
    chk({tag, "_wb_data"}, 32'(wb_data), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, d0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    #19 rst_n = 1'b1;

    // 1: load, ack in the third REQ cycle
    ack_mode = 1; ack_delay = 2; use_fixed = 1; fixed_rdata = 16'hBEEF;
    w0 = wb_cnt;
    issue(1'b0, 4'd3, 16'h0040, 16'h0000);
    wait_done();
    chk("t1_wb_write", 32'(wb_write), 32'd1);
    chk("t1_wb_reg", 32'(wb_reg), 32'd3);
    chk("t1_wb_data", 32'(wb_data), 32'hBEEF);
    chk("t1_error", 32'(error), 32'd0);
    repeat (3) @(negedge clk);
    chk("t1_wb_pulses", 32'(wb_cnt - w0), 32'd1);

    // 2: store, ack in the first REQ cycle
    ack_delay = 0;
    w0 = wb_cnt;
    wait_idle();
    start = 1'b1; is_store = 1'b1; dest_reg = 4'd5; address = 16'h1234; store_data = 16'hA5A5;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("t2_mem_req", 32'(mem_req), 32'd1);
    chk("t2_mem_we", 32'(mem_we), 32'd1);
    chk("t2_mem_addr", 32'(mem_addr), 32'h1234);
    chk("t2_mem_wdata", 32'(mem_wdata), 32'hA5A5);
    @(negedge clk);
    chk("t2_done_n2", 32'(done), 32'd1);
    repeat (2) @(negedge clk);
    chk("t2_no_wb", 32'(wb_cnt - w0), 32'd0);

    // 3: timeout, late ack ignored, next start clears error
    ack_mode = 0;
    r0 = req_hi_cnt; w0 = wb_cnt;
    issue(1'b0, 4'd6, 16'h0100, 16'h0000);
    wait_done();
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_wb_write", 32'(wb_write), 32'd0);
    chk("t3_req_cycles", 32'(req_hi_cnt - r0), 32'(TO));
    noise = 1'b1;
    repeat (6) @(negedge clk);
    noise = 1'b0;
    chk("t3_error_held", 32'(error), 32'd1);
    chk("t3_idle", 32'(busy), 32'd0);
    chk("t3_no_wb", 32'(wb_cnt - w0), 32'd0);
    ack_mode = 1; ack_delay = 0;
    issue(1'b1, 4'd0, 16'h0200, 16'h0001);
    @(negedge clk);
    chk("t3_error_cleared", 32'(error), 32'd0);

    // 4: start held for 10 edges, ack in the first REQ cycle
    wait_idle();
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) begin
      start = 1'b1; is_store = 1'($urandom_range(0, 1)); dest_reg = 4'($urandom);
      address = AW'($urandom); store_data = DW'($urandom);
      tick();
    end
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("t4_accepted", 32'(done_cnt - d0), 32'd4);

    // 5: asynchronous reset in the middle of a REQ cycle
    ack_mode = 0;
    issue(1'b0, 4'd2, 16'h0F0F, 16'h0000);
    @(negedge clk);
    chk("t5_in_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t5");
    @(negedge clk);
    #2 rst_n = 1'b1;
    ack_mode = 1; ack_delay = 1; fixed_rdata = 16'hC0DE;
    issue(1'b0, 4'd9, 16'h0044, 16'h0000);
    wait_done();
    chk("t5_wb_write", 32'(wb_write), 32'd1);
    chk("t5_wb_reg", 32'(wb_reg), 32'd9);
    chk("t5_wb_data", 32'(wb_data), 32'hC0DE);

    // 6: ack on the same edge the wait counter reaches TIMEOUT
    ack_delay = TO - 1; fixed_rdata = 16'h1357;
    r0 = req_hi_cnt;
    issue(1'b0, 4'd7, 16'h0777, 16'h0000);
    wait_done();
    chk("t6_error", 32'(error), 32'd0);
    chk("t6_wb_write", 32'(wb_write), 32'd1);
    chk("t6_wb_reg", 32'(wb_reg), 32'd7);
    chk("t6_wb_data", 32'(wb_data), 32'h1357);
    chk("t6_req_cycles", 32'(req_hi_cnt - r0), 32'(TO));

    // randomized traffic, input churn during REQ, random ack delays and stray acks
    ack_mode = 2; use_fixed = 1'b0; noise = 1'b1;
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 2) == 0);
      is_store = 1'($urandom_range(0, 1)); dest_reg = 4'($urandom);
      address = AW'($urandom); store_data = DW'($urandom);
      tick();
    end
    start = 1'b0; noise = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
